// File: rtl/mul_xxbit_shift_unit.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock; product valid DATA_WIDTH+1 edges after reset release.
// Define MUL_XXBIT_SHIFT_SIGNED_EN for two's-complement operands (magnitude multiply, sign fixed up on entry to DONE).
module mul_xxbit_shift_unit #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATA_WIDTH-1:0]     i_num_a,
  input  logic [DATA_WIDTH-1:0]     i_num_b,
  output logic                      o_end,
  output logic [2*DATA_WIDTH-1:0]   o_res
);

  localparam int RES_W = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_CALC,
    S_DONE
  } state_t;

  state_t                state, state_nx;
  logic [RES_W-1:0]      mcand, mcand_nx;
  logic [RES_W-1:0]      acc, acc_nx;
  logic [RES_W-1:0]      sum, final_res;
  logic [RES_W-1:0]      res_nx;
  logic [DATA_WIDTH-1:0] mplier, mplier_nx;
  logic [DATA_WIDTH-1:0] mag_a, mag_b;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic                  end_nx;

`ifdef MUL_XXBIT_SHIFT_SIGNED_EN
  logic sign, sign_nx;

  // Most-negative operand negates to itself, which read unsigned is the correct magnitude.
  assign mag_a     = i_num_a[DATA_WIDTH-1] ? (~i_num_a + 1'b1) : i_num_a;
  assign mag_b     = i_num_b[DATA_WIDTH-1] ? (~i_num_b + 1'b1) : i_num_b;
  assign final_res = sign ? (~sum + 1'b1) : sum;
`else
  assign mag_a     = i_num_a;
  assign mag_b     = i_num_b;
  assign final_res = sum;
`endif

  assign sum = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_LOAD;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      o_end  <= 1'b0;
      o_res  <= '0;
`ifdef MUL_XXBIT_SHIFT_SIGNED_EN
      sign   <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      mcand  <= mcand_nx;
      mplier <= mplier_nx;
      acc    <= acc_nx;
      cnt    <= cnt_nx;
      o_end  <= end_nx;
      o_res  <= res_nx;
`ifdef MUL_XXBIT_SHIFT_SIGNED_EN
      sign   <= sign_nx;
`endif
    end
  end

  always_comb begin
    state_nx  = state;
    mcand_nx  = mcand;
    mplier_nx = mplier;
    acc_nx    = acc;
    cnt_nx    = cnt;
    end_nx    = o_end;
    res_nx    = o_res;
`ifdef MUL_XXBIT_SHIFT_SIGNED_EN
    sign_nx   = sign;
`endif
    case (state)
      S_LOAD: begin
        mcand_nx  = {{DATA_WIDTH{1'b0}}, mag_a};
        mplier_nx = mag_b;
        acc_nx    = '0;
        cnt_nx    = '0;
`ifdef MUL_XXBIT_SHIFT_SIGNED_EN
        sign_nx   = i_num_a[DATA_WIDTH-1] ^ i_num_b[DATA_WIDTH-1];
`endif
        state_nx  = S_CALC;
      end
      S_CALC: begin
        acc_nx    = sum;
        mcand_nx  = mcand << 1;
        mplier_nx = mplier >> 1;
        cnt_nx    = cnt + CNT_W'(1);
        // Outputs are registered on the last CALC edge so they are valid right after it.
        if (cnt == CNT_LAST) begin
          acc_nx   = final_res;
          res_nx   = final_res;
          end_nx   = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
      end
      default: begin
        state_nx = S_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_xxbit_shift_unit.sv
// Directed-vector bench for mul_xxbit_shift_unit (DATA_WIDTH = 4); expected products depend on MUL_XXBIT_SHIFT_SIGNED_EN.
module tb_mul_xxbit_shift_unit;

  logic       clk;
  logic       rst;
  logic [3:0] num_a;
  logic [3:0] num_b;
  logic       done;
  logic [7:0] res;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    string      name;
  } vec_t;

  vec_t vecs[8];

  mul_xxbit_shift_unit #(.DATA_WIDTH(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_num_a (num_a),
    .i_num_b (num_b),
    .o_end   (done),
    .o_res   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] exp);
    n_cmp++;
    if ({done, res} !== exp) begin
      n_bad++;
      $display("FAIL %s: got end=%0b res=%h, want end=%0b res=%h", name, done, res, exp[8], exp[7:0]);
    end
  endtask

  // Pulse reset with the operands applied, checking the asynchronous clear.
  task automatic start(input logic [3:0] a, input logic [3:0] b, input string name);
    @(negedge clk);
    rst   = 1'b1;
    num_a = a;
    num_b = b;
    #1;
    check({name, "_rst_clear"}, 9'h000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full run: outputs zero through edge 4, product after edge 5, then held.
  task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p,
                     input string name, input bit scramble);
    start(a, b, name);
    for (int unsigned e = 1; e <= 4; e++) begin
      @(negedge clk);
      if (scramble) begin
        num_a = ~a;
        num_b = b ^ 4'h6;
      end
      check($sformatf("%s_edge%0d", name, e), 9'h000);
    end
    @(negedge clk);
    check({name, "_result"}, {1'b1, p});
    num_a = 4'h3;
    num_b = 4'hC;
    for (int unsigned h = 0; h < 2; h++) begin
      @(negedge clk);
      check($sformatf("%s_hold%0d", name, h), {1'b1, p});
    end
  endtask

  initial begin
`ifdef MUL_XXBIT_SHIFT_SIGNED_EN
    vecs[0] = '{4'b1010, 4'b1001, 8'h2A, "m6_m7"};
    vecs[1] = '{4'b1010, 4'b0101, 8'hE2, "m6_p5"};
    vecs[2] = '{4'hF,    4'hF,    8'h01, "m1_m1"};
    vecs[3] = '{4'h0,    4'hB,    8'h00, "zero_a"};
    vecs[4] = '{4'h1,    4'h1,    8'h01, "one_one"};
    vecs[5] = '{4'b1000, 4'b1000, 8'h40, "mneg_mneg"};
    vecs[6] = '{4'b1111, 4'b0001, 8'hFF, "m1_p1"};
    vecs[7] = '{4'b0111, 4'b1000, 8'hC8, "p7_m8"};
`else
    vecs[0] = '{4'b1010, 4'b1001, 8'h5A, "a10_b9"};
    vecs[1] = '{4'b1010, 4'b0101, 8'h32, "a10_b5"};
    vecs[2] = '{4'hF,    4'hF,    8'hE1, "max_max"};
    vecs[3] = '{4'h0,    4'hB,    8'h00, "zero_a"};
    vecs[4] = '{4'h1,    4'h1,    8'h01, "one_one"};
    vecs[5] = '{4'b1000, 4'b1000, 8'h40, "a8_b8"};
    vecs[6] = '{4'b1111, 4'b0001, 8'h0F, "a15_b1"};
    vecs[7] = '{4'b0111, 4'b1000, 8'h38, "a7_b8"};
`endif

    rst   = 1'b1;
    num_a = 4'h0;
    num_b = 4'h0;
    #3;
    check("reset_state", 9'h000);

    foreach (vecs[i]) run(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name, 1'b0);

    // Reset during the CALC edge 3 aborts asynchronously.
    start(vecs[0].a, vecs[0].b, "abort");
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_async_clear", 9'h000);
    @(negedge clk);
    check("abort_held_clear", 9'h000);
    run(vecs[2].a, vecs[2].b, vecs[2].p, "after_abort", 1'b0);

    // Operands changed after LOAD must not affect the product.
    run(vecs[0].a, vecs[0].b, vecs[0].p, "scramble", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
